// File: rtl/ecall_controller_pkg.sv
// Shared constants, state encoding and helpers for the ECALL service controller.
package ecall_controller_pkg;

  localparam int unsigned XLEN_DEF      = 32;
  localparam int unsigned DISP_HOLD_DEF = 8;
  localparam int unsigned SYS_PRINT_DEF = 1;
  localparam int unsigned SYS_READ_DEF  = 5;
  localparam int unsigned SYS_EXIT_DEF  = 10;

  localparam logic [31:0] ECALL_OPCODE = 32'h0000_0073;
  localparam logic [4:0]  ECALL_RD     = 5'd10;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRINT     = 3'd1,
    ST_READ_WAIT = 3'd2,
    ST_READ_WB   = 3'd3,
    ST_DONE      = 3'd4,
    ST_HALT      = 3'd5
  } state_e;

  // States in which the core must stay frozen regardless of the bus contents.
  function automatic logic is_stall_state(input state_e s);
    return (s == ST_PRINT) || (s == ST_READ_WAIT) || (s == ST_READ_WB) || (s == ST_HALT);
  endfunction

endpackage

// File: rtl/ecall_controller_btn_sync_edge.sv
// Two-flop synchroniser for an asynchronous push button plus a rising-edge pulse.
// The history flop updates every cycle, so a button held across any window never
// produces a late edge.
module ecall_controller_btn_sync_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_i,
  output logic rise_c_o
);

  logic [1:0] sync_q;
  logic       prev_q;

  // Synchroniser chain followed by the edge-detect history flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 2'b00;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn_i};
      prev_q <= sync_q[1];
    end
  end

  assign rise_c_o = sync_q[1] & ~prev_q;

endmodule

// File: rtl/ecall_controller.sv
// ECALL service sequencer: stalls the core and runs print / read / exit services
// selected by a7, taking over the x10 write port to return read data.
module ecall_controller
  import ecall_controller_pkg::*;
#(
  parameter int unsigned XLEN      = XLEN_DEF,
  parameter int unsigned DISP_HOLD = DISP_HOLD_DEF,
  parameter int unsigned SYS_PRINT = SYS_PRINT_DEF,
  parameter int unsigned SYS_READ  = SYS_READ_DEF,
  parameter int unsigned SYS_EXIT  = SYS_EXIT_DEF
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            instr_valid,
  input  logic [31:0]     instruction,
  input  logic [XLEN-1:0] a7,
  input  logic [XLEN-1:0] a0,
  input  logic [XLEN-1:0] sw_in,
  input  logic            confirm_btn,
  output logic            stall,
  output logic            halted,
  output logic            ecall_we,
  output logic [4:0]      ecall_waddr,
  output logic [XLEN-1:0] ecall_wdata,
  output logic [XLEN-1:0] disp_data,
  output logic            disp_valid,
  output logic            bad_ecall
);

  localparam int unsigned CNT_W = $clog2(DISP_HOLD) + 1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   rd_buf_q, rd_buf_d;
  logic [XLEN-1:0]   disp_data_q, disp_data_d;
  logic              disp_valid_q, disp_valid_d;
  logic              halted_q;
  logic              ecall_we_q;
  logic              hit;
  logic              confirm_rise;

  ecall_controller_btn_sync_edge u_confirm (
    .clk      (clk),
    .reset_n  (reset_n),
    .btn_i    (confirm_btn),
    .rise_c_o (confirm_rise)
  );

  // An ECALL is only decoded from IDLE; DONE lets the PC step past it.
  assign hit   = instr_valid && (instruction == ECALL_OPCODE) && (state_q == ST_IDLE);
  assign stall = hit || is_stall_state(state_q);

  // Next-state, service datapath and the combinational bad-code pulse.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rd_buf_d     = rd_buf_q;
    disp_data_d  = disp_data_q;
    disp_valid_d = disp_valid_q;
    bad_ecall    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (hit) begin
          if (a7 == XLEN'(SYS_PRINT)) begin
            state_d      = ST_PRINT;
            disp_data_d  = a0;
            disp_valid_d = 1'b1;
            cnt_d        = CNT_W'(DISP_HOLD - 1);
          end else if (a7 == XLEN'(SYS_READ)) begin
            state_d = ST_READ_WAIT;
          end else if (a7 == XLEN'(SYS_EXIT)) begin
            state_d = ST_HALT;
          end else begin
            bad_ecall = 1'b1;
            state_d   = ST_DONE;
          end
        end
      end
      ST_PRINT: begin
        if (cnt_q == '0) state_d = ST_DONE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_READ_WAIT: begin
        if (confirm_rise) begin
          rd_buf_d = sw_in;
          state_d  = ST_READ_WB;
        end
      end
      ST_READ_WB: state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      ST_HALT:    state_d = ST_HALT;
      default:    state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; write-enable and halted follow the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      rd_buf_q     <= '0;
      disp_data_q  <= '0;
      disp_valid_q <= 1'b0;
      halted_q     <= 1'b0;
      ecall_we_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rd_buf_q     <= rd_buf_d;
      disp_data_q  <= disp_data_d;
      disp_valid_q <= disp_valid_d;
      halted_q     <= (state_d == ST_HALT);
      ecall_we_q   <= (state_d == ST_READ_WB);
    end
  end

  assign halted      = halted_q;
  assign ecall_we    = ecall_we_q;
  assign ecall_waddr = ECALL_RD;
  assign ecall_wdata = rd_buf_q;
  assign disp_data   = disp_data_q;
  assign disp_valid  = disp_valid_q;

endmodule

// File: tb/tb_ecall_controller.sv
// Scoreboarded bench for ecall_controller: each issued ECALL pushes the expected
// service outcome; a monitor measures every stall window and compares at its end.
module tb_ecall_controller;

  localparam int unsigned XLEN = 32;
  localparam int unsigned HOLD = 4;
  localparam logic [31:0] ECALL = 32'h0000_0073;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            instr_valid = 1'b0;
  logic [31:0]     instruction = NOP;
  logic [XLEN-1:0] a7 = '0;
  logic [XLEN-1:0] a0 = '0;
  logic [XLEN-1:0] sw_in = '0;
  logic            confirm_btn = 1'b0;
  logic            stall, halted, ecall_we, disp_valid, bad_ecall;
  logic [4:0]      ecall_waddr;
  logic [XLEN-1:0] ecall_wdata, disp_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          len;
    int          n_we;
    logic [31:0] wdata;
    int          n_bad;
    logic [31:0] disp;
    logic        dvalid;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_disp = '0;
  logic        m_valid = 1'b0;

  ecall_controller #(.XLEN(XLEN), .DISP_HOLD(HOLD)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .instr_valid (instr_valid),
    .instruction (instruction),
    .a7          (a7),
    .a0          (a0),
    .sw_in       (sw_in),
    .confirm_btn (confirm_btn),
    .stall       (stall),
    .halted      (halted),
    .ecall_we    (ecall_we),
    .ecall_waddr (ecall_waddr),
    .ecall_wdata (ecall_wdata),
    .disp_data   (disp_data),
    .disp_valid  (disp_valid),
    .bad_ecall   (bad_ecall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: measures each stall window and compares against the next expectation.
  int          run_len = 0;
  int          run_we = 0;
  int          run_bad = 0;
  logic [31:0] run_wdata = '0;

  always @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_len = 0;
      run_we  = 0;
      run_bad = 0;
    end else begin
      if (ecall_we) begin
        run_we++;
        run_wdata = ecall_wdata;
        chk("waddr", 32'(ecall_waddr), 32'd10);
      end
      if (bad_ecall) begin
        run_bad++;
        chk("bad_in_hit_cycle", 32'(run_len), 32'd0);
      end
      if (stall) begin
        run_len++;
      end else if (run_len > 0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_service: stall window of %0d cycles with nothing expected", run_len);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (e.len >= 0) chk("stall_len", 32'(run_len), 32'(e.len));
          chk("we_count", 32'(run_we), 32'(e.n_we));
          if (e.n_we > 0) chk("wdata", run_wdata, e.wdata);
          chk("bad_count", 32'(run_bad), 32'(e.n_bad));
          chk("disp_data", disp_data, e.disp);
          chk("disp_valid", 32'(disp_valid), 32'(e.dvalid));
        end
        run_len = 0;
        run_we  = 0;
        run_bad = 0;
      end
    end
  end

  // Core model: hold the ECALL until the first unstalled cycle, then advance.
  // Called and returns just after a rising edge.
  task automatic run_ecall(input logic [31:0] a7v, input logic [31:0] a0v,
                           input int press, input int rel);
    int cyc;
    a7 = a7v;
    a0 = a0v;
    instruction = ECALL;
    instr_valid = 1'b1;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (!stall) break;
      if (cyc > 200) begin
        checks++;
        errors++;
        $display("FAIL ecall_timeout: stall still %b after %0d cycles", stall, cyc);
        break;
      end
      @(posedge clk); #1;
      cyc++;
      if (cyc == rel) confirm_btn = 1'b0;
      if (cyc == press) confirm_btn = 1'b1;
    end
    @(posedge clk); #1;
    instr_valid = 1'b0;
    instruction = NOP;
    confirm_btn = 1'b0;
  endtask

  // Reference model: service outcome derived from the a7 code and button timing.
  // A read press in cycle p is synchronised by two flops, latched on the next
  // edge and written back one cycle later, so the stall window is p + 4 cycles.
  task automatic issue(input logic [31:0] a7v, input logic [31:0] a0v,
                       input int press, input int rel);
    exp_t e;
    e.n_we  = 0;
    e.wdata = '0;
    e.n_bad = 0;
    if (a7v == 32'd1) begin
      m_disp  = a0v;
      m_valid = 1'b1;
      e.len   = 1 + HOLD;
    end else if (a7v == 32'd5) begin
      e.len   = press + 4;
      e.n_we  = 1;
      e.wdata = sw_in;
    end else begin
      e.len   = 1;
      e.n_bad = 1;
    end
    e.disp   = m_disp;
    e.dvalid = m_valid;
    exp_q.push_back(e);
    run_ecall(a7v, a0v, press, rel);
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_stall"}, 32'(stall), 32'd0);
    chk({tag, "_halted"}, 32'(halted), 32'd0);
    chk({tag, "_we"}, 32'(ecall_we), 32'd0);
    chk({tag, "_bad"}, 32'(bad_ecall), 32'd0);
    chk({tag, "_wdata"}, ecall_wdata, 32'd0);
    chk({tag, "_disp_data"}, disp_data, 32'd0);
    chk({tag, "_disp_valid"}, 32'(disp_valid), 32'd0);
  endtask

  // Asynchronous reset mid-cycle, checked before any clock edge arrives.
  task automatic async_reset(input string tag);
    instr_valid = 1'b0;
    instruction = NOP;
    #2 reset_n = 1'b0;
    #1 chk_cleared(tag);
    m_disp  = '0;
    m_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    int          n_ok;
    int          n_spurious;
    logic [31:0] v;

    #1 chk_cleared("reset");
    #11 reset_n = 1'b1;
    @(posedge clk); #1;

    // Directed print, read, held-button read, unsupported codes.
    issue(32'd1, 32'h0000_1234, -1, -1);
    sw_in = 32'h0000_ABCD;
    issue(32'd5, '0, 10, -1);
    sw_in = 32'h0000_5A5A;
    confirm_btn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    issue(32'd5, '0, 12, 5);
    issue(32'd3, 32'h1111_1111, -1, -1);
    issue(32'h0001_0001, '0, -1, -1);
    issue(32'd0, '0, -1, -1);

    // Randomised services separated by idle gaps with stray button activity.
    for (int k = 0; k < 25; k++) begin
      int r;
      int gap;
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) begin
        instr_valid = 1'($urandom);
        instruction = instr_valid ? NOP : ECALL;
        confirm_btn = 1'($urandom);
        @(posedge clk); #1;
      end
      instr_valid = 1'b0;
      instruction = NOP;
      confirm_btn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      r = int'($urandom_range(0, 5));
      sw_in = $urandom;
      if (r <= 1) begin
        issue(32'd1, $urandom, -1, -1);
      end else if (r <= 3) begin
        issue(32'd5, '0, int'($urandom_range(1, 20)), -1);
      end else if (r == 4) begin
        do v = 32'($urandom_range(0, 15)); while (v == 32'd1 || v == 32'd5 || v == 32'd10);
        issue(v, '0, -1, -1);
      end else begin
        issue($urandom | 32'h0000_0100, '0, -1, -1);
      end
    end

    // Reset while waiting for the confirm button.
    issue(32'd1, 32'h0000_0077, -1, -1);
    sw_in = 32'hCAFE_F00D;
    a7 = 32'd5;
    instruction = ECALL;
    instr_valid = 1'b1;
    repeat (6) @(negedge clk);
    chk("read_wait_stall", 32'(stall), 32'd1);
    @(posedge clk);
    async_reset("rst_read");
    issue(32'd1, 32'h0000_1234, -1, -1);

    // Exit: permanent stall; later ECALLs are ignored.
    a7 = 32'd10;
    instruction = ECALL;
    instr_valid = 1'b1;
    n_ok = 0;
    n_spurious = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (stall && (halted || i == 0)) n_ok++;
      if (ecall_we || bad_ecall) n_spurious++;
      if (i == 50) begin
        a7 = 32'd1;
        a0 = 32'hDEAD_BEEF;
      end
      if (i == 70) a7 = 32'd3;
    end
    chk("halt_cycles", 32'(n_ok), 32'd120);
    chk("halt_spurious", 32'(n_spurious), 32'd0);
    chk("halt_disp", disp_data, m_disp);
    @(posedge clk);
    async_reset("rst_halt");
    issue(32'd1, 32'h0000_1234, -1, -1);

    repeat (4) @(posedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
